// File: rtl/d_flip_flop.sv
// Parameterised D-type register: captures d on each rising clk edge.
// An asynchronous active-low reset loads RESET_VALUE without waiting for a clock edge.
module d_flip_flop #(
    parameter int                 WIDTH       = 1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Reset wins over the clock, so q stays at RESET_VALUE while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_d_flip_flop.sv
// Directed bench for d_flip_flop: a 1-bit default instance and an 8-bit instance with reset value 8'hA5.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge and again mid-cycle.
module tb_d_flip_flop;

    logic       clk;
    logic       reset;
    logic       d1;
    logic       q1;
    logic [7:0] d8;
    logic [7:0] q8;

    int n_tests;
    int n_fail;

    d_flip_flop u_dut1 (
        .clk   (clk),
        .reset (reset),
        .d     (d1),
        .q     (q1)
    );

    d_flip_flop #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .d     (d8),
        .q     (q8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("[TB] ok   %s: q=%h (t=%0t)", tag, obs, $time);
        end
    endtask

    // Drive d on the falling edge, check after the next rising edge and again just before the following falling edge.
    task automatic step(input logic v1, input logic [7:0] v8,
                        input logic e1, input logic [7:0] e8, input string tag);
        @(negedge clk);
        d1 = v1;
        d8 = v8;
        @(posedge clk);
        #1;
        check({tag, "_q1"}, {7'b0, q1}, {7'b0, e1});
        check({tag, "_q8"}, q8, e8);
        #3;
        check({tag, "_q1_hold"}, {7'b0, q1}, {7'b0, e1});
        check({tag, "_q8_hold"}, q8, e8);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        d1      = 1'b0;
        d8      = 8'h00;

        // Reset asserted before any clock edge must take effect immediately.
        #2 reset = 1'b0;
        #1;
        check("rst_async_q1", {7'b0, q1}, 8'h00);
        check("rst_async_q8", q8, 8'hA5);

        d1 = 1'b1;
        d8 = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_q1", {7'b0, q1}, 8'h00);
        check("rst_hold_q8", q8, 8'hA5);

        @(negedge clk);
        reset = 1'b1;
        d1    = 1'b0;
        d8    = 8'h00;
        @(posedge clk);
        #1;
        check("release_q1", {7'b0, q1}, 8'h00);
        check("release_q8", q8, 8'h00);

        // Toggle every two cycles.
        step(1'b1, 8'h3C, 1'b1, 8'h3C, "tog_a");
        step(1'b1, 8'h3C, 1'b1, 8'h3C, "tog_b");
        step(1'b0, 8'h5A, 1'b0, 8'h5A, "tog_c");
        step(1'b0, 8'h5A, 1'b0, 8'h5A, "tog_d");
        step(1'b1, 8'hC3, 1'b1, 8'hC3, "tog_e");

        // Irregular hold lengths: 3 cycles high, 4 low, 1 high.
        step(1'b1, 8'h01, 1'b1, 8'h01, "irr_a");
        step(1'b1, 8'h01, 1'b1, 8'h01, "irr_b");
        step(1'b1, 8'h80, 1'b1, 8'h80, "irr_c");
        step(1'b0, 8'hFE, 1'b0, 8'hFE, "irr_d");
        step(1'b0, 8'hFE, 1'b0, 8'hFE, "irr_e");
        step(1'b0, 8'h7F, 1'b0, 8'h7F, "irr_f");
        step(1'b0, 8'h7F, 1'b0, 8'h7F, "irr_g");
        step(1'b1, 8'h00, 1'b1, 8'h00, "irr_h");
        step(1'b0, 8'h00, 1'b0, 8'h00, "irr_i");

        // Short pulses and toggles around the falling edge, none spanning a rising edge.
        @(posedge clk);
        #2 d1 = 1'b1; d8 = 8'hFF;
        #1 d1 = 1'b0; d8 = 8'h00;
        #1 d1 = 1'b1; d8 = 8'hAA;
        #2 d1 = 1'b0; d8 = 8'h00;
        @(posedge clk);
        #1;
        check("pulse_q1", {7'b0, q1}, 8'h00);
        check("pulse_q8", q8, 8'h00);

        // Reset asserted mid-cycle while q holds a nonzero value.
        step(1'b1, 8'h96, 1'b1, 8'h96, "pre_rst");
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_q1", {7'b0, q1}, 8'h00);
        check("mid_rst_q8", q8, 8'hA5);
        d1 = 1'b1;
        d8 = 8'h77;
        #10;
        check("rst_edge_q1", {7'b0, q1}, 8'h00);
        check("rst_edge_q8", q8, 8'hA5);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_q1", {7'b0, q1}, 8'h01);
        check("post_rst_q8", q8, 8'h77);
        step(1'b0, 8'h00, 1'b0, 8'h00, "post_rst_b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
